// File: rtl/ddos_flow_counter_pkg.sv
// Shared definitions for the DDoS per-source flow counter: default widths,
// FSM state encoding and the entry field-width helper.
package ddos_flow_counter_pkg;

  localparam int DEF_BRAM_WIDTH     = 37;
  localparam int DEF_MAX_DEPTH_BITS = 14;
  localparam int DEF_KEY_WIDTH      = 32;
  localparam int DEF_CNT_WIDTH      = 16;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_RESP
  } state_e;

  // Entry = {valid, tag, count}; the tag takes whatever is left over.
  function automatic int tag_width(input int bram_w, input int cnt_w);
    return bram_w - 1 - cnt_w;
  endfunction

endpackage

// File: rtl/ddos_flow_counter_if.sv
// Lookup request/verdict handshake plus the single-port BRAM client bus.
interface ddos_flow_counter_if
  import ddos_flow_counter_pkg::*;
#(
  parameter int KEY_WIDTH      = DEF_KEY_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int MAX_DEPTH_BITS = DEF_MAX_DEPTH_BITS,
  parameter int BRAM_WIDTH     = DEF_BRAM_WIDTH
) ();

  logic                      req_valid;
  logic                      req_ready;
  logic [KEY_WIDTH-1:0]      req_key;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_drop;
  logic                      rsp_hit;
  logic [CNT_WIDTH-1:0]      rsp_count;
  logic [MAX_DEPTH_BITS-1:0] bram_addr;
  logic                      bram_wr_en;
  logic [BRAM_WIDTH-1:0]     bram_wr_data;
  logic [BRAM_WIDTH-1:0]     bram_rd_data;

  // The counter block itself.
  modport slave (
    input  req_valid, req_key, rsp_ready, bram_rd_data,
    output req_ready, rsp_valid, rsp_drop, rsp_hit, rsp_count,
           bram_addr, bram_wr_en, bram_wr_data
  );

  // Requester, verdict consumer and BRAM side.
  modport master (
    output req_valid, req_key, rsp_ready, bram_rd_data,
    input  req_ready, rsp_valid, rsp_drop, rsp_hit, rsp_count,
           bram_addr, bram_wr_en, bram_wr_data
  );

endinterface

// File: rtl/ddos_flow_counter_entry_update.sv
// Combinational entry update: tag compare, saturating increment,
// threshold compare and the entry to write back.
module ddos_flow_counter_entry_update
  import ddos_flow_counter_pkg::*;
#(
  parameter int BRAM_WIDTH = DEF_BRAM_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic [BRAM_WIDTH-1:0]                        rd_entry_i,
  input  logic [tag_width(BRAM_WIDTH, CNT_WIDTH)-1:0]  key_tag_i,
  input  logic [CNT_WIDTH-1:0]                         threshold_i,
  output logic                                         hit_o,
  output logic                                         drop_o,
  output logic [CNT_WIDTH-1:0]                         count_o,
  output logic [BRAM_WIDTH-1:0]                        entry_o
);

  localparam int TAG_WIDTH = tag_width(BRAM_WIDTH, CNT_WIDTH);
  localparam int VALID_BIT = BRAM_WIDTH - 1;
  localparam int TAG_MSB   = BRAM_WIDTH - 2;
  localparam int TAG_LSB   = CNT_WIDTH;
  localparam int CNT_MSB   = CNT_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic                 rd_vld;
  logic [TAG_WIDTH-1:0] rd_tag;
  logic [CNT_WIDTH-1:0] rd_cnt;

  assign rd_vld = rd_entry_i[VALID_BIT];
  assign rd_tag = rd_entry_i[TAG_MSB:TAG_LSB];
  assign rd_cnt = rd_entry_i[CNT_MSB:0];

  assign hit_o = rd_vld && (rd_tag == key_tag_i);

  // A miss claims the slot for the new key with a fresh count of one.
  always_comb begin
    count_o = CNT_ONE;
    if (hit_o) count_o = (&rd_cnt) ? rd_cnt : rd_cnt + CNT_ONE;
  end

  assign drop_o  = count_o > threshold_i;
  assign entry_o = {1'b1, key_tag_i, count_o};

endmodule

// File: rtl/ddos_flow_counter.sv
// Per-source request counter for the DDoS filter: read-modify-write client of
// an external read-first BRAM, with a full-table sweep after reset / epoch clear.
module ddos_flow_counter
  import ddos_flow_counter_pkg::*;
#(
  parameter int BRAM_WIDTH     = DEF_BRAM_WIDTH,
  parameter int MAX_DEPTH_BITS = DEF_MAX_DEPTH_BITS,
  parameter int KEY_WIDTH      = DEF_KEY_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic                 clear_req,
  output logic                 clear_busy,
  ddos_flow_counter_if.slave   bus
);

  localparam int TAG_WIDTH = tag_width(BRAM_WIDTH, CNT_WIDTH);
  localparam logic [MAX_DEPTH_BITS:0] PTR_ONE = 1;

  state_e                    state_q;
  logic [MAX_DEPTH_BITS:0]   ptr_q;     // MSB set once every slot has been written
  logic [TAG_WIDTH-1:0]      tag_q;
  logic                      clr_pend_q;
  logic                      busy_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic                      rsp_drop_q;
  logic                      rsp_hit_q;
  logic [CNT_WIDTH-1:0]      rsp_count_q;
  logic [MAX_DEPTH_BITS-1:0] addr_q;
  logic                      wr_en_q;
  logic [BRAM_WIDTH-1:0]     wr_data_q;

  logic                      hit_d;
  logic                      drop_d;
  logic [CNT_WIDTH-1:0]      cnt_d;
  logic [BRAM_WIDTH-1:0]     entry_d;

  ddos_flow_counter_entry_update #(
    .BRAM_WIDTH (BRAM_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_upd (
    .rd_entry_i  (bus.bram_rd_data),
    .key_tag_i   (tag_q),
    .threshold_i (threshold),
    .hit_o       (hit_d),
    .drop_o      (drop_d),
    .count_o     (cnt_d),
    .entry_o     (entry_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      tag_q       <= '0;
      clr_pend_q  <= 1'b0;
      busy_q      <= 1'b1;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_drop_q  <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_count_q <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          wr_data_q <= '0;
          if (ptr_q[MAX_DEPTH_BITS]) begin
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            wr_en_q <= 1'b1;
            addr_q  <= ptr_q[MAX_DEPTH_BITS-1:0];
            ptr_q   <= ptr_q + PTR_ONE;
          end
        end

        ST_IDLE: begin
          // A request already handshaken on this edge is honoured; a clear
          // pulse on the same edge then waits behind its response.
          if (bus.req_valid && req_ready_q) begin
            tag_q       <= TAG_WIDTH'(bus.req_key[KEY_WIDTH-1:MAX_DEPTH_BITS]);
            addr_q      <= bus.req_key[MAX_DEPTH_BITS-1:0];
            wr_en_q     <= 1'b0;
            req_ready_q <= 1'b0;
            clr_pend_q  <= clear_req;
            state_q     <= ST_READ;
          end else if (clear_req) begin
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
            ptr_q       <= '0;
            state_q     <= ST_CLEAR;
          end
        end

        ST_READ: begin
          clr_pend_q <= clr_pend_q | clear_req;
          state_q    <= ST_EVAL;
        end

        ST_EVAL: begin
          clr_pend_q  <= clr_pend_q | clear_req;
          wr_en_q     <= 1'b1;
          wr_data_q   <= entry_d;
          rsp_hit_q   <= hit_d;
          rsp_drop_q  <= drop_d;
          rsp_count_q <= cnt_d;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end

        ST_RESP: begin
          wr_en_q <= 1'b0;
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (clr_pend_q || clear_req) begin
              clr_pend_q <= 1'b0;
              busy_q     <= 1'b1;
              ptr_q      <= '0;
              state_q    <= ST_CLEAR;
            end else begin
              req_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end else begin
            clr_pend_q <= clr_pend_q | clear_req;
          end
        end

        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign clear_busy       = busy_q;
  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_drop     = rsp_drop_q;
  assign bus.rsp_hit      = rsp_hit_q;
  assign bus.rsp_count    = rsp_count_q;
  assign bus.bram_addr    = addr_q;
  assign bus.bram_wr_en   = wr_en_q;
  assign bus.bram_wr_data = wr_data_q;

endmodule

// File: tb/tb_ddos_flow_counter.sv
// Directed bench for ddos_flow_counter with a 16-entry read-first BRAM model.
module tb_ddos_flow_counter;

  localparam int KW = 32;
  localparam int CW = 16;
  localparam int DB = 4;
  localparam int BW = 45;   // 1 + 28-bit tag + 16-bit count, so 32-bit keys fit

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] threshold;
  logic          clear_req;
  logic          clear_busy;

  int n_checks = 0;
  int n_fail   = 0;

  ddos_flow_counter_if #(.KEY_WIDTH(KW), .CNT_WIDTH(CW), .MAX_DEPTH_BITS(DB), .BRAM_WIDTH(BW)) bus ();

  ddos_flow_counter #(.BRAM_WIDTH(BW), .MAX_DEPTH_BITS(DB), .KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .threshold  (threshold),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Read-first BRAM model with a preload port for the bench.
  logic [BW-1:0] mem [16];
  logic          pl_en;
  logic [DB-1:0] pl_addr;
  logic [BW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.bram_wr_en) mem[bus.bram_addr] <= bus.bram_wr_data;
    bus.bram_rd_data <= mem[bus.bram_addr];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Observes one sweep; returns writes seen, bad writes, whether busy fell
  // right after the last write, and response pulses seen during the sweep.
  task automatic wait_sweep(output int nwr, output int bad, output bit fell_ok, output int rspv);
    bit prev_wr = 1'b0;
    nwr = 0; bad = 0; fell_ok = 1'b0; rspv = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.rsp_valid) rspv++;
      if (bus.bram_wr_en) begin
        if (bus.bram_addr !== 4'(nwr) || bus.bram_wr_data !== '0 || !clear_busy) bad++;
        nwr++;
      end
      if (!clear_busy) begin
        fell_ok = prev_wr && !bus.bram_wr_en;
        break;
      end
      prev_wr = bus.bram_wr_en;
    end
  endtask

  task automatic lookup(input logic [KW-1:0] key, output logic hit, output logic [CW-1:0] cnt,
                        output logic drop, output int lat);
    int w = 0;
    while (!bus.req_ready && w < 50) begin tick(); w++; end
    if (!bus.req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL req_ready_timeout: key %h never accepted", key);
    end
    bus.req_valid = 1'b1; bus.req_key = key;
    tick();
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 10) begin tick(); lat++; end
    hit = bus.rsp_hit; cnt = bus.rsp_count; drop = bus.rsp_drop;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int nwr, bad, rspv; bit fell;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (clear_busy !== 1'b1) begin n_fail++; $display("FAIL rst_clear_busy: got %b want 1", clear_busy); end
    n_checks++; if (bus.bram_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", bus.bram_wr_en); end
    n_checks++; if ({bus.rsp_count, bus.bram_addr, bus.bram_wr_data, bus.rsp_hit, bus.rsp_drop} !== '0) begin
      n_fail++; $display("FAIL rst_outputs_zero: count %h addr %h data %h", bus.rsp_count, bus.bram_addr, bus.bram_wr_data);
    end
    reset_n = 1'b1;
    wait_sweep(nwr, bad, fell, rspv);
    n_checks++; if (nwr !== 16) begin n_fail++; $display("FAIL sweep_writes: got %0d want 16", nwr); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sweep_addr_data: %0d bad writes want 0", bad); end
    n_checks++; if (fell !== 1'b1) begin n_fail++; $display("FAIL sweep_busy_fall: got %b want 1", fell); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_count();
    logic h, d; logic [CW-1:0] c; int lat;
    for (int i = 0; i < 3; i++) begin
      lookup(32'h0A000005, h, c, d, lat);
      n_checks++; if (h !== (i != 0)) begin n_fail++; $display("FAIL cnt_hit[%0d]: got %b want %b", i, h, i != 0); end
      n_checks++; if (c !== CW'(i + 1)) begin n_fail++; $display("FAIL cnt_count[%0d]: got %0d want %0d", i, c, i + 1); end
      n_checks++; if (d !== (i == 2)) begin n_fail++; $display("FAIL cnt_drop[%0d]: got %b want %b", i, d, i == 2); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL cnt_latency[%0d]: got %0d want 2", i, lat); end
    end
    n_checks++; if (mem[5] !== {1'b1, 28'h0A00000, 16'd3}) begin
      n_fail++; $display("FAIL cnt_entry: got %h want %h", mem[5], {1'b1, 28'h0A00000, 16'd3});
    end
  endtask

  task automatic test_replace();
    logic h, d; logic [CW-1:0] c; int lat;
    lookup(32'h0B000005, h, c, d, lat);
    n_checks++; if ({h, c, d} !== {1'b0, 16'd1, 1'b0}) begin n_fail++; $display("FAIL repl_new: hit %b count %0d drop %b want 0 1 0", h, c, d); end
    n_checks++; if (mem[5] !== {1'b1, 28'h0B00000, 16'd1}) begin
      n_fail++; $display("FAIL repl_entry: got %h want %h", mem[5], {1'b1, 28'h0B00000, 16'd1});
    end
    lookup(32'h0A000005, h, c, d, lat);
    n_checks++; if ({h, c} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL repl_old_miss: hit %b count %0d want 0 1", h, c); end
  endtask

  task automatic test_saturate();
    logic h, d; logic [CW-1:0] c; int lat;
    threshold = 16'hFFFF;
    pl_en = 1'b1; pl_addr = 4'd7; pl_data = {1'b1, 28'h0C00000, 16'hFFFF};
    tick();
    pl_en = 1'b0;
    lookup(32'h0C000007, h, c, d, lat);
    n_checks++; if ({h, c, d} !== {1'b1, 16'hFFFF, 1'b0}) begin n_fail++; $display("FAIL sat: hit %b count %h drop %b want 1 ffff 0", h, c, d); end
    threshold = 16'd2;
  endtask

  task automatic test_clear_in_eval();
    logic h, d; logic [CW-1:0] c; int lat, nwr, bad, rspv; bit fell;
    bus.req_valid = 1'b1; bus.req_key = 32'h0A000005;
    tick();                      // handshake edge; now READ
    bus.req_valid = 1'b0;
    tick();                      // EVAL
    clear_req = 1'b1;
    tick();                      // RESP
    clear_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_count, bus.rsp_drop, clear_busy} !== {1'b1, 1'b1, 16'd2, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL hold[%0d]: valid %b hit %b count %0d drop %b busy %b want 1 1 2 0 0", i,
                           bus.rsp_valid, bus.rsp_hit, bus.rsp_count, bus.rsp_drop, clear_busy);
      end
      if (i < 5) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    n_checks++; if ({clear_busy, bus.rsp_valid, bus.req_ready} !== 3'b100) begin
      n_fail++; $display("FAIL clr_after_rsp: busy %b valid %b ready %b want 1 0 0", clear_busy, bus.rsp_valid, bus.req_ready);
    end
    wait_sweep(nwr, bad, fell, rspv);
    n_checks++; if (nwr !== 16 || bad !== 0) begin n_fail++; $display("FAIL clr_sweep: writes %0d bad %0d want 16 0", nwr, bad); end
    lookup(32'h0A000005, h, c, d, lat);
    n_checks++; if ({h, c} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL clr_fresh: hit %b count %0d want 0 1", h, c); end
  endtask

  task automatic test_clear_idle();
    int nwr, bad, rspv; bit fell;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n_checks++; if ({clear_busy, bus.req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL idle_clr: busy %b ready %b want 1 0", clear_busy, bus.req_ready);
    end
    wait_sweep(nwr, bad, fell, rspv);
    n_checks++; if (nwr !== 16 || bad !== 0 || !fell) begin n_fail++; $display("FAIL idle_sweep: writes %0d bad %0d fell %b want 16 0 1", nwr, bad, fell); end
  endtask

  task automatic test_reset_in_resp();
    logic h, d; logic [CW-1:0] c; int lat, nwr, bad, rspv; bit fell;
    bus.req_valid = 1'b1; bus.req_key = 32'h0D000009;
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();              // RESP
    tick();                      // write-back to slot 9 has landed
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_pre_valid: got %b want 1", bus.rsp_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({bus.rsp_valid, clear_busy, bus.bram_wr_en} !== 3'b010) begin
      n_fail++; $display("FAIL rr_async: valid %b busy %b wr_en %b want 0 1 0", bus.rsp_valid, clear_busy, bus.bram_wr_en);
    end
    tick(); tick();
    reset_n = 1'b1;
    wait_sweep(nwr, bad, fell, rspv);
    n_checks++; if (nwr !== 16 || bad !== 0) begin n_fail++; $display("FAIL rr_sweep: writes %0d bad %0d want 16 0", nwr, bad); end
    n_checks++; if (rspv !== 0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_stale: %0d stale cycles valid %b want 0 0", rspv, bus.rsp_valid); end
    lookup(32'h0D000009, h, c, d, lat);
    n_checks++; if ({h, c} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL rr_fresh: hit %b count %0d want 0 1", h, c); end
  endtask

  initial begin
    reset_n = 1'b0; threshold = 16'd2; clear_req = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.req_valid = 1'b0; bus.req_key = '0; bus.rsp_ready = 1'b0;
    tick(); tick();
    test_reset();
    test_count();
    test_replace();
    test_saturate();
    test_clear_in_eval();
    test_clear_idle();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddos_flow_counter.md
Name: ddos_flow_counter

Overview:
- Read-modify-write client that drives a single-port, read-first BRAM table: `addr`, `wr_en`, `in_data` out; registered `out_data` back, one cycle read latency.
- Keeps a per-source-key request counter for the DDoS filter.
- For each lookup it reads the entry, checks the tag, increments or replaces the entry, writes it back and returns a drop/pass verdict.
- Also sweeps the table to zero after reset and on an epoch-clear request.

Parameters:
- BRAM_WIDTH, 37, table entry width; must equal the BRAM instance width.
- MAX_DEPTH_BITS, 14, table index width; table depth TOTAL_NUM = 2**MAX_DEPTH_BITS.
- KEY_WIDTH, 32, lookup key width (IPv4 source address).
- CNT_WIDTH, 16, counter field width.
- TAG_WIDTH, BRAM_WIDTH-1-CNT_WIDTH (20), tag field width; requires KEY_WIDTH-MAX_DEPTH_BITS <= TAG_WIDTH.

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request valid
- req_ready  out  1  block can accept a request
- req_key  in  KEY_WIDTH  lookup key
- threshold  in  CNT_WIDTH  drop threshold, sampled in EVAL
- clear_req  in  1  one-cycle pulse: zero the whole table
- clear_busy  out  1  sweep in progress
- rsp_valid  out  1  verdict valid
- rsp_ready  in  1  downstream accepts verdict
- rsp_drop  out  1  1 = counter exceeds threshold
- rsp_hit  out  1  1 = valid entry with matching tag
- rsp_count  out  CNT_WIDTH  counter value after update
- bram_addr  out  MAX_DEPTH_BITS  to BRAM addr
- bram_wr_en  out  1  to BRAM wr_en
- bram_wr_data  out  BRAM_WIDTH  to BRAM in_data
- bram_rd_data  in  BRAM_WIDTH  from BRAM out_data

Behaviour:
- Entry layout: [BRAM_WIDTH-1] valid; [BRAM_WIDTH-2:CNT_WIDTH] tag; [CNT_WIDTH-1:0] count.
- Index = req_key[MAX_DEPTH_BITS-1:0]; tag = req_key[KEY_WIDTH-1:MAX_DEPTH_BITS], zero-extended to TAG_WIDTH.
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_drop=0, rsp_hit=0, rsp_count=0, bram_wr_en=0, bram_addr=0, bram_wr_data=0, clear_busy=1. State=CLEAR, sweep pointer=0.
- FSM states: CLEAR, IDLE, READ, EVAL, RESP.
- CLEAR:
  - Each cycle: bram_wr_en=1, bram_wr_data=0, bram_addr=pointer; pointer increments.
  - After address TOTAL_NUM-1 is written: go to IDLE, clear_busy=0, bram_wr_en=0.
  - Takes exactly TOTAL_NUM write cycles.
- IDLE:
  - req_ready=1 only here, and only when no clear is pending.
  - A pending clear goes to CLEAR ahead of any request.
  - Handshake at edge E0 (req_valid & req_ready): latch key, bram_addr<=index, bram_wr_en<=0, go to READ.
- READ: BRAM captures at edge E1; go to EVAL.
- EVAL: bram_rd_data is valid.
  - Hit (valid & tag equal): count' = count+1, saturating at all-ones.
  - Miss or invalid: replace entry with {1, tag, 1}.
  - Drop = count' > threshold (unsigned).
  - At edge E2: bram_wr_en<=1, bram_wr_data<={1, tag, count'}, rsp_* loaded, rsp_valid<=1; go to RESP.
- RESP:
  - BRAM write occurs at edge E3; bram_wr_en<=0 at E3.
  - rsp_valid and the rsp_* fields are held stable until rsp_ready.
  - On response handshake: go to IDLE.
- Latency: rsp_valid rises 2 cycles after the request handshake edge.
- Throughput: at most one lookup per 4 cycles.
- Back-to-back requests to the same key see the prior write, because the write completes at E3, before the next READ can start.
- clear_req:
  - In IDLE: CLEAR starts the next cycle.
  - During READ/EVAL/RESP: latched, executed after the response handshake.
  - During CLEAR: ignored; no restart.
  - clear_busy=1 from the cycle after the clear_req edge until the sweep ends.
- Reset mid-operation: immediate abort; in-flight response dropped; the partially written entry is irrelevant because a full sweep follows.
- Threshold changes take effect for any lookup whose EVAL follows the change.

Decomposition:
- Shared include ddos_pkg.vh holds:
  - entry field offsets (VALID_BIT, TAG_MSB/LSB, CNT_MSB/LSB);
  - FSM state encodings;
  - default widths, shared with the BRAM instantiation.
- One sub-module, ddos_entry_update: combinational tag compare, saturating increment, threshold compare and new-entry build.
- The parent design instantiates BRAM next to ddos_flow_counter; the BRAM is not nested inside this block.

Test Plan (MAX_DEPTH_BITS=4, threshold=2 unless noted):
- Reset release -> clear_busy=1 for exactly 16 cycles with bram_wr_en=1 at addresses 0..15, data 0; then req_ready=1.
- Key 0x0A000005 three times -> rsp_hit 0,1,1; rsp_count 1,2,3; rsp_drop 0,0,1; rsp_valid 2 cycles after each handshake.
- Key 0x0A000005 then 0x0B000005 (same index, different tag) -> second: rsp_hit=0, rsp_count=1; entry tag replaced; 0x0A000005 then misses.
- Threshold=0xFFFF, entry preloaded with count 0xFFFF and matching tag -> rsp_count=0xFFFF (saturates), rsp_drop=0.
- clear_req in EVAL, rsp_ready held low 5 cycles -> verdict held stable; CLEAR starts only after the rsp handshake; the next lookup of the same key gets rsp_count=1.
- reset_n asserted during RESP -> rsp_valid=0 immediately and asynchronously; full sweep reruns; no stale response appears.
